ara_acc_req_frontend: RTL and testbench

Accelerator-side endpoint of the CVA6 accelerator request/response interface. Requests that the scalar core has already predecoded as vector instructions arrive here with their scalar operands. The block buffers them, classifies which ones need a scalar write-back, and forwards them in order to Ara's dispatcher. It returns exactly one in-order response per request to CVA6, tagged with the transaction ID, and carries the dispatcher-produced result for write-back instructions.

---
 rtl/ara_acc_req_frontend.sv | 160 ++++++++++++++++
 tb/tb_ara_acc_req_frontend.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ara_acc_req_frontend.sv
// Accelerator-side endpoint of the CVA6 request/response interface: buffers predecoded
// vector requests, forwards them in order to the dispatcher and returns one in-order response each.
module ara_acc_req_frontend #(
  parameter int unsigned Depth       = 4,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned TransIdBits = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   acc_req_valid_i,
  output logic                   acc_req_ready_o,
  input  logic [31:0]            acc_req_insn_i,
  input  logic [XLEN-1:0]        acc_req_rs1_i,
  input  logic [XLEN-1:0]        acc_req_rs2_i,
  input  logic [TransIdBits-1:0] acc_req_trans_id_i,
  output logic                   disp_valid_o,
  input  logic                   disp_ready_i,
  output logic [31:0]            disp_insn_o,
  output logic [XLEN-1:0]        disp_rs1_o,
  output logic [XLEN-1:0]        disp_rs2_o,
  output logic                   disp_wb_o,
  input  logic                   disp_resp_valid_i,
  input  logic [XLEN-1:0]        disp_resp_result_i,
  input  logic                   disp_resp_error_i,
  output logic                   acc_resp_valid_o,
  input  logic                   acc_resp_ready_i,
  output logic [XLEN-1:0]        acc_resp_result_o,
  output logic                   acc_resp_error_o,
  output logic [TransIdBits-1:0] acc_resp_trans_id_o,
  output logic                   protocol_err_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthCnt = (CntW + 1)'(Depth);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high; a valid
  // source holds its data stable until that cycle, and ready never depends on valid.
  logic [31:0]            req_insn_q [Depth];
  logic [XLEN-1:0]        req_rs1_q  [Depth];
  logic [XLEN-1:0]        req_rs2_q  [Depth];
  logic [TransIdBits-1:0] req_id_q   [Depth];
  logic [Depth-1:0]       req_wb_q;
  logic [PtrW-1:0]        req_wr_q, req_rd_q;
  logic [CntW-1:0]        req_count_q;

  logic [TransIdBits-1:0] trk_id_q     [Depth];
  logic [XLEN-1:0]        trk_result_q [Depth];
  logic [Depth-1:0]       trk_wb_q, trk_done_q, trk_error_q;
  logic [PtrW-1:0]        trk_head_q, trk_tail_q;
  logic [CntW-1:0]        trk_count_q;

  logic            push, pop, retire, push_wb, cap_found, capture;
  logic [PtrW-1:0] cap_idx;
  logic [CntW:0]   used_cnt;

  // Only scalar-returning vector ops: vsetvl*, VWXUNARY0 and VFWUNARY0.
  always_comb begin
    push_wb = 1'b0;
    if (acc_req_insn_i[6:0] == 7'b1010111) begin
      case (acc_req_insn_i[14:12])
        3'b111:        push_wb = 1'b1;
        3'b010, 3'b001: push_wb = (acc_req_insn_i[31:26] == 6'b010000);
        default:       push_wb = 1'b0;
      endcase
    end
  end

  // Credits come from registered counts only, so the tracker always has room on dispatch.
  assign used_cnt        = {1'b0, req_count_q} + {1'b0, trk_count_q};
  assign acc_req_ready_o = used_cnt < DepthCnt;
  assign push            = acc_req_valid_i && acc_req_ready_o;
  assign disp_valid_o    = (req_count_q != '0);
  assign pop             = disp_valid_o && disp_ready_i;
  assign disp_insn_o     = req_insn_q[req_rd_q];
  assign disp_rs1_o      = req_rs1_q[req_rd_q];
  assign disp_rs2_o      = req_rs2_q[req_rd_q];
  assign disp_wb_o       = req_wb_q[req_rd_q];

  assign acc_resp_valid_o    = (trk_count_q != '0) && trk_done_q[trk_head_q];
  assign retire              = acc_resp_valid_o && acc_resp_ready_i;
  assign acc_resp_result_o   = trk_result_q[trk_head_q];
  assign acc_resp_error_o    = trk_error_q[trk_head_q];
  assign acc_resp_trans_id_o = trk_id_q[trk_head_q];

  // Oldest registered write-back entry still waiting; a same-cycle allocation is never visible here.
  always_comb begin
    cap_found = 1'b0;
    cap_idx   = '0;
    for (int i = 0; i < Depth; i++) begin
      if (!cap_found && (CntW'(i) < trk_count_q) && trk_wb_q[trk_head_q + PtrW'(i)]
          && !trk_done_q[trk_head_q + PtrW'(i)]) begin
        cap_found = 1'b1;
        cap_idx   = trk_head_q + PtrW'(i);
      end
    end
  end

  assign capture = disp_resp_valid_i && cap_found;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        req_insn_q[i] <= '0;
        req_rs1_q[i]  <= '0;
        req_rs2_q[i]  <= '0;
        req_id_q[i]   <= '0;
      end
      req_wb_q    <= '0;
      req_wr_q    <= '0;
      req_rd_q    <= '0;
      req_count_q <= '0;
    end else begin
      if (push) begin
        req_insn_q[req_wr_q] <= acc_req_insn_i;
        req_rs1_q[req_wr_q]  <= acc_req_rs1_i;
        req_rs2_q[req_wr_q]  <= acc_req_rs2_i;
        req_id_q[req_wr_q]   <= acc_req_trans_id_i;
        req_wb_q[req_wr_q]   <= push_wb;
        req_wr_q             <= req_wr_q + 1'b1;
      end
      if (pop) req_rd_q <= req_rd_q + 1'b1;
      req_count_q <= req_count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        trk_id_q[i]     <= '0;
        trk_result_q[i] <= '0;
      end
      trk_wb_q       <= '0;
      trk_done_q     <= '0;
      trk_error_q    <= '0;
      trk_head_q     <= '0;
      trk_tail_q     <= '0;
      trk_count_q    <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      if (pop) begin
        trk_id_q[trk_tail_q]     <= req_id_q[req_rd_q];
        trk_wb_q[trk_tail_q]     <= req_wb_q[req_rd_q];
        trk_done_q[trk_tail_q]   <= !req_wb_q[req_rd_q];
        trk_result_q[trk_tail_q] <= '0;
        trk_error_q[trk_tail_q]  <= 1'b0;
        trk_tail_q               <= trk_tail_q + 1'b1;
      end
      if (capture) begin
        trk_done_q[cap_idx]   <= 1'b1;
        trk_result_q[cap_idx] <= disp_resp_result_i;
        trk_error_q[cap_idx]  <= disp_resp_error_i;
      end
      if (disp_resp_valid_i && !cap_found) protocol_err_o <= 1'b1;
      if (retire) trk_head_q <= trk_head_q + 1'b1;
      trk_count_q <= trk_count_q + CntW'(pop) - CntW'(retire);
    end
  end

endmodule

// File: tb/tb_ara_acc_req_frontend.sv
// Directed bench for ara_acc_req_frontend: dispatch and response traffic are
// compared against expected queues filled when each request is accepted.
module tb_ara_acc_req_frontend;
  localparam int XLEN = 64;
  localparam int TID  = 3;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            acc_req_valid = 1'b0, acc_req_ready;
  logic [31:0]     acc_req_insn = '0;
  logic [XLEN-1:0] acc_req_rs1 = '0, acc_req_rs2 = '0;
  logic [TID-1:0]  acc_req_id = '0;
  logic            disp_valid, disp_ready = 1'b1, disp_wb;
  logic [31:0]     disp_insn;
  logic [XLEN-1:0] disp_rs1, disp_rs2;
  logic            disp_resp_valid = 1'b0, disp_resp_error = 1'b0;
  logic [XLEN-1:0] disp_resp_result = '0;
  logic            acc_resp_valid, acc_resp_ready = 1'b1, acc_resp_error, protocol_err;
  logic [XLEN-1:0] acc_resp_result;
  logic [TID-1:0]  acc_resp_id;

  ara_acc_req_frontend #(.Depth(4), .XLEN(XLEN), .TransIdBits(TID)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .acc_req_valid_i(acc_req_valid), .acc_req_ready_o(acc_req_ready),
    .acc_req_insn_i(acc_req_insn), .acc_req_rs1_i(acc_req_rs1), .acc_req_rs2_i(acc_req_rs2),
    .acc_req_trans_id_i(acc_req_id),
    .disp_valid_o(disp_valid), .disp_ready_i(disp_ready), .disp_insn_o(disp_insn),
    .disp_rs1_o(disp_rs1), .disp_rs2_o(disp_rs2), .disp_wb_o(disp_wb),
    .disp_resp_valid_i(disp_resp_valid), .disp_resp_result_i(disp_resp_result),
    .disp_resp_error_i(disp_resp_error),
    .acc_resp_valid_o(acc_resp_valid), .acc_resp_ready_i(acc_resp_ready),
    .acc_resp_result_o(acc_resp_result), .acc_resp_error_o(acc_resp_error),
    .acc_resp_trans_id_o(acc_resp_id), .protocol_err_o(protocol_err)
  );

  // clock / reset
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [160:0] disp_exp_q[$];
  logic [67:0]  exp_q[$];
  logic [160:0] dexp;
  logic [67:0]  rexp;
  int checks = 0, failures = 0;
  int disp_cnt = 0, resp_cnt = 0;
  int unsigned last_disp_cyc = 0, last_resp_cyc = 0, acc_cyc = 0, strobe_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && disp_valid && disp_ready) begin
      disp_cnt++;
      last_disp_cyc = cyc;
      checks++;
      if (disp_exp_q.size() == 0) begin
        failures++;
        $display("FAIL disp_unexpected actual_insn=%08h required=none", disp_insn);
      end else begin
        dexp = disp_exp_q.pop_front();
        if ({disp_insn, disp_rs1, disp_rs2, disp_wb} !== dexp) begin
          failures++;
          $display("FAIL disp_pkt actual=%0h required=%0h", {disp_insn, disp_rs1, disp_rs2, disp_wb}, dexp);
        end
      end
    end
    if (rst_n && acc_resp_valid && acc_resp_ready) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected actual_id=%0d required=none", acc_resp_id);
      end else begin
        rexp = exp_q.pop_front();
        if ({acc_resp_id, acc_resp_error, acc_resp_result} !== rexp) begin
          failures++;
          $display("FAIL resp_pkt actual=%0h required=%0h", {acc_resp_id, acc_resp_error, acc_resp_result}, rexp);
        end
      end
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic send(input logic [31:0] insn, input logic [63:0] rs1, input logic [63:0] rs2,
                      input logic [2:0] id, input logic wb, input logic [63:0] res, input logic err);
    bit done = 0;
    acc_req_valid = 1'b1; acc_req_insn = insn; acc_req_rs1 = rs1; acc_req_rs2 = rs2; acc_req_id = id;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (acc_req_ready) begin
        done = 1;
        acc_cyc = cyc;
        disp_exp_q.push_back({insn, rs1, rs2, wb});
        exp_q.push_back({id, err, res});
      end
      @(posedge clk); #1;
    end
    acc_req_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted id=%0d", id);
    end
  endtask

  task automatic pulse_result(input logic [63:0] res, input logic err);
    disp_resp_valid = 1'b1; disp_resp_result = res; disp_resp_error = err;
    strobe_cyc = cyc;
    @(posedge clk); #1;
    disp_resp_valid = 1'b0; disp_resp_result = '0; disp_resp_error = 1'b0;
  endtask

  task automatic wait_disp(input int n);
    for (int i = 0; i < 100 && disp_cnt < n; i++) begin @(posedge clk); #1; end
    if (disp_cnt < n) begin
      checks++; failures++;
      $display("FAIL wait_disp actual=%0d required=%0d", disp_cnt, n);
    end
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 100 && resp_cnt < n; i++) begin @(posedge clk); #1; end
    if (resp_cnt < n) begin
      checks++; failures++;
      $display("FAIL wait_resp actual=%0d required=%0d", resp_cnt, n);
    end
  endtask

  localparam logic [31:0] VADD = 32'h02008057;

  logic [31:0] cls_insn [5] = '{32'h42001057, 32'h02007007, 32'h02002057, 32'h02001057, 32'h00007027};
  logic        cls_wb   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  int accepted;
  int k;
  int base_d, base_r;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(acc_req_ready), 64'd1);
    check("rst_disp_valid", 64'(disp_valid), 64'd0);
    check("rst_resp_valid", 64'(acc_resp_valid), 64'd0);
    check("rst_perr", 64'(protocol_err), 64'd0);
    check("rst_disp_insn", 64'(disp_insn), 64'd0);
    check("rst_resp_result", acc_resp_result, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single vadd: dispatch one cycle after accept, response one cycle after dispatch
    send(VADD, 64'h1111, 64'h2222, 3'd1, 1'b0, 64'd0, 1'b0);
    wait_resp(1);
    check("vadd_disp_lat", 64'(last_disp_cyc - acc_cyc), 64'd1);
    check("vadd_resp_lat", 64'(last_resp_cyc - last_disp_cyc), 64'd1);

    // vsetvli with result 0x10 three cycles after dispatch
    send(32'h00007057, 64'h40, 64'h0, 3'd2, 1'b1, 64'h10, 1'b0);
    wait_disp(2);
    repeat (2) begin @(posedge clk); #1; end
    pulse_result(64'h10, 1'b0);
    wait_resp(2);
    check("vset_resp_lat", 64'(last_resp_cyc - strobe_cyc), 64'd1);

    // vmv.x.s then two vadds: younger finished responses wait behind the write-back
    send(32'h420022D7, 64'h3, 64'h33, 3'd3, 1'b1, 64'hDEADBEEF, 1'b0);
    send(VADD, 64'h4, 64'h44, 3'd4, 1'b0, 64'd0, 1'b0);
    send(VADD, 64'h5, 64'h55, 3'd5, 1'b0, 64'd0, 1'b0);
    wait_disp(5);
    repeat (3) begin @(posedge clk); #1; end
    check("held_resp_valid", 64'(acc_resp_valid), 64'd0);
    check("held_resp_cnt", 64'(resp_cnt), 64'd2);
    pulse_result(64'hDEADBEEF, 1'b0);
    wait_resp(5);
    check("ordered_drain_lat", 64'(last_resp_cyc - strobe_cyc), 64'd3);

    // classification table
    for (int i = 0; i < 5; i++) begin
      base_d = disp_cnt; base_r = resp_cnt;
      send(cls_insn[i], 64'(i) * 64'h0101, 64'hA5A5, 3'(6 + i), cls_wb[i],
           cls_wb[i] ? 64'h1234 : 64'h0, cls_wb[i]);
      wait_disp(base_d + 1);
      if (cls_wb[i]) pulse_result(64'h1234, 1'b1);
      wait_resp(base_r + 1);
    end

    // credit limit: dispatcher stalled, six requests offered, four accepted
    disp_ready = 1'b0;
    accepted = 0; k = 0;
    base_d = disp_cnt; base_r = resp_cnt;
    acc_req_valid = 1'b1; acc_req_insn = VADD | 32'(k << 7); acc_req_id = 3'(k);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (acc_req_ready && acc_req_valid) begin
        accepted++;
        disp_exp_q.push_back({acc_req_insn, acc_req_rs1, acc_req_rs2, 1'b0});
        exp_q.push_back({acc_req_id, 1'b0, 64'd0});
        k++;
      end
      @(posedge clk); #1;
      acc_req_insn = VADD | 32'(k << 7); acc_req_id = 3'(k);
      if (k == 6) acc_req_valid = 1'b0;
    end
    acc_req_valid = 1'b0;
    check("credit_accepted", 64'(accepted), 64'd4);
    check("credit_ready_low", 64'(acc_req_ready), 64'd0);
    acc_resp_ready = 1'b0;
    disp_ready = 1'b1;
    wait_disp(base_d + 4);
    disp_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("tracker_full_ready", 64'(acc_req_ready), 64'd0);
    acc_resp_ready = 1'b1;
    @(negedge clk);
    check("retire_cycle_ready", 64'(acc_req_ready), 64'd0);
    @(negedge clk);
    check("after_retire_ready", 64'(acc_req_ready), 64'd1);
    @(posedge clk); #1;
    wait_resp(base_r + 4);
    disp_ready = 1'b1;

    // stray dispatcher result with only a wb=0 entry outstanding
    acc_resp_ready = 1'b0;
    base_d = disp_cnt; base_r = resp_cnt;
    send(VADD, 64'h7, 64'h77, 3'd2, 1'b0, 64'd0, 1'b0);
    wait_disp(base_d + 1);
    check("perr_before", 64'(protocol_err), 64'd0);
    pulse_result(64'h55, 1'b0);
    check("perr_set", 64'(protocol_err), 64'd1);
    check("perr_resp_result", acc_resp_result, 64'd0);
    check("perr_resp_valid", 64'(acc_resp_valid), 64'd1);
    acc_resp_ready = 1'b1;
    wait_resp(base_r + 1);
    repeat (3) begin @(posedge clk); #1; end
    check("perr_sticky", 64'(protocol_err), 64'd1);

    // reset with three buffered requests and one pending response
    acc_resp_ready = 1'b0;
    base_d = disp_cnt;
    send(VADD, 64'h8, 64'h88, 3'd4, 1'b0, 64'd0, 1'b0);
    wait_disp(base_d + 1);
    disp_ready = 1'b0;
    send(VADD, 64'h9, 64'h99, 3'd5, 1'b0, 64'd0, 1'b0);
    send(32'h00007057, 64'hA, 64'hAA, 3'd6, 1'b1, 64'd0, 1'b0);
    send(VADD, 64'hB, 64'hBB, 3'd7, 1'b0, 64'd0, 1'b0);
    check("pre_rst_disp_valid", 64'(disp_valid), 64'd1);
    check("pre_rst_resp_valid", 64'(acc_resp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_disp_valid", 64'(disp_valid), 64'd0);
    check("async_rst_resp_valid", 64'(acc_resp_valid), 64'd0);
    check("async_rst_perr", 64'(protocol_err), 64'd0);
    disp_exp_q.delete();
    exp_q.delete();
    base_d = disp_cnt; base_r = resp_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    disp_ready = 1'b1;
    acc_resp_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("post_rst_disp_cnt", 64'(disp_cnt), 64'(base_d));
    check("post_rst_resp_cnt", 64'(resp_cnt), 64'(base_r));
    check("post_rst_resp_valid", 64'(acc_resp_valid), 64'd0);
    check("post_rst_disp_insn", 64'(disp_insn), 64'd0);
    check("post_rst_req_ready", 64'(acc_req_ready), 64'd1);

    // final report
    check("disp_q_left", 64'(disp_exp_q.size()), 64'd0);
    check("resp_q_left", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
